mm_led_ctrl: RTL and testbench



---
 rtl/mm_led_pkg.sv | 19 +
 rtl/mm_led_timebase.sv | 42 ++++
 rtl/mm_led_ctrl.sv | 104 ++++++++++
 tb/tb_mm_led_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_led_pkg.sv
// Shared constants for the memory-mapped LED controller: bus widths,
// register word offsets and STATUS field positions.
package mm_led_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_OUT       = 3'd0;
    localparam logic [ADDR_W-1:0] REG_BLINK_EN  = 3'd1;
    localparam logic [ADDR_W-1:0] REG_PWM_EN    = 3'd2;
    localparam logic [ADDR_W-1:0] REG_BLINK_DIV = 3'd3;
    localparam logic [ADDR_W-1:0] REG_DUTY      = 3'd4;
    localparam logic [ADDR_W-1:0] REG_TOGGLE    = 3'd5;
    localparam logic [ADDR_W-1:0] REG_STATUS    = 3'd6;

    localparam int unsigned STATUS_PHASE_BIT = 0;
    localparam int unsigned STATUS_PWM_LSB   = 8;

endpackage

// File: rtl/mm_led_timebase.sv
// Shared timebase for all LED channels: blink prescaler/phase and a
// free-running PWM counter compared against the programmed duty.
module mm_led_timebase
    import mm_led_pkg::*;
#(
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned BLINK_DIV_BITS = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BLINK_DIV_BITS-1:0] div,
    input  logic                      div_wr,
    input  logic [PWM_BITS-1:0]       duty,
    output logic                      phase,
    output logic [PWM_BITS-1:0]       pwm_cnt,
    output logic                      pwm_on
);

    logic [BLINK_DIV_BITS-1:0] cnt;

    // A BLINK_DIV write restarts the half-period without touching phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            phase   <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (div_wr) begin
                cnt <= '0;
            end else if (cnt == div) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + BLINK_DIV_BITS'(1);
            end
        end
    end

    assign pwm_on = (pwm_cnt < duty);

endmodule

// File: rtl/mm_led_ctrl.sv
// Memory-mapped LED controller: register file, single-cycle ready
// handshake and registered per-channel blink/PWM output stage.
module mm_led_ctrl
    import mm_led_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 6,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned BLINK_DIV_BITS = 24,
    parameter int unsigned BLINK_DIV_RST  = 13_499_999
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                select,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_i,
    input  logic                write_en,
    output logic                ready,
    output logic [DATA_W-1:0]   data_o,
    output logic [NUM_LEDS-1:0] leds
);

    logic [NUM_LEDS-1:0]       out_r;
    logic [NUM_LEDS-1:0]       blink_en;
    logic [NUM_LEDS-1:0]       pwm_en;
    logic [BLINK_DIV_BITS-1:0] blink_div;
    logic [PWM_BITS-1:0]       duty;

    logic                      phase;
    logic [PWM_BITS-1:0]       pwm_cnt;
    logic                      pwm_on;

    logic                      accept_c;
    logic                      wr_c;
    logic                      div_wr_c;
    logic [DATA_W-1:0]         rdata_c;
    logic                      unused_data_c;

    assign accept_c      = select & ~ready;
    assign wr_c          = accept_c & write_en;
    assign div_wr_c      = wr_c & (addr == REG_BLINK_DIV);
    assign unused_data_c = ^data_i;

    mm_led_timebase #(
        .PWM_BITS       (PWM_BITS),
        .BLINK_DIV_BITS (BLINK_DIV_BITS)
    ) u_timebase (
        .clk     (clk),
        .reset   (reset),
        .div     (blink_div),
        .div_wr  (div_wr_c),
        .duty    (duty),
        .phase   (phase),
        .pwm_cnt (pwm_cnt),
        .pwm_on  (pwm_on)
    );

    // Read mux; unimplemented bits and write-only/reserved offsets read 0.
    always_comb begin
        rdata_c = '0;
        case (addr)
            REG_OUT:       rdata_c = DATA_W'(out_r);
            REG_BLINK_EN:  rdata_c = DATA_W'(blink_en);
            REG_PWM_EN:    rdata_c = DATA_W'(pwm_en);
            REG_BLINK_DIV: rdata_c = DATA_W'(blink_div);
            REG_DUTY:      rdata_c = DATA_W'(duty);
            REG_STATUS: begin
                rdata_c[STATUS_PHASE_BIT]              = phase;
                rdata_c[STATUS_PWM_LSB +: PWM_BITS]    = pwm_cnt;
            end
            default:       rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready     <= 1'b0;
            data_o    <= '0;
            leds      <= '0;
            out_r     <= '0;
            blink_en  <= '0;
            pwm_en    <= '0;
            blink_div <= BLINK_DIV_BITS'(BLINK_DIV_RST);
            duty      <= '0;
        end else begin
            ready  <= accept_c;
            data_o <= accept_c ? rdata_c : '0;
            leds   <= out_r
                    & (~blink_en | {NUM_LEDS{phase}})
                    & (~pwm_en   | {NUM_LEDS{pwm_on}});
            if (wr_c) begin
                case (addr)
                    REG_OUT:       out_r     <= data_i[NUM_LEDS-1:0];
                    REG_BLINK_EN:  blink_en  <= data_i[NUM_LEDS-1:0];
                    REG_PWM_EN:    pwm_en    <= data_i[NUM_LEDS-1:0];
                    REG_BLINK_DIV: blink_div <= data_i[BLINK_DIV_BITS-1:0];
                    REG_DUTY:      duty      <= data_i[PWM_BITS-1:0];
                    REG_TOGGLE:    out_r     <= out_r ^ data_i[NUM_LEDS-1:0];
                    default:       ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mm_led_ctrl.sv
// Self-checking bench for mm_led_ctrl: scoreboarded bus reads plus
// per-feature scenarios for blink, PWM, handshake and reset.
module tb_mm_led_ctrl;
    import mm_led_pkg::*;

    localparam int unsigned N   = 6;
    localparam int unsigned PB  = 8;
    localparam int unsigned BDB = 24;
    localparam int unsigned BDR = 13_499_999;

    typedef struct {
        logic        chk;
        logic [31:0] val;
        logic [2:0]  a;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          select;
    logic          write_en;
    logic [2:0]    addr;
    logic [31:0]   data_i;
    logic          ready;
    logic [31:0]   data_o;
    logic [N-1:0]  leds;

    int   n_vec   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   rst_cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    mm_led_ctrl #(
        .NUM_LEDS       (N),
        .PWM_BITS       (PB),
        .BLINK_DIV_BITS (BDB),
        .BLINK_DIV_RST  (BDR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .select   (select),
        .addr     (addr),
        .data_i   (data_i),
        .write_en (write_en),
        .ready    (ready),
        .data_o   (data_o),
        .leds     (leds)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every ready pulse must match a queued access.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL ready_spurious: got ready=1 with no access pending");
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk && data_o !== mon_e.val) begin
                    n_err++;
                    $display("FAIL rdata[%0d]: got %h want %h", mon_e.a, data_o, mon_e.val);
                end
            end
        end
    end

    function automatic logic [31:0] status_now();
        return 32'((cyc - rst_cyc) % 256) << STATUS_PWM_LSB;
    endfunction

    task automatic do_reset();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_ready: got %0d pending want 0", exp_q.size());
        end
        exp_q.delete();
        reset = 1'b1; select = 1'b0; write_en = 1'b0; addr = '0; data_i = '0;
        @(posedge clk); #1;
        rst_cyc = cyc;
        reset = 1'b0;
    endtask

    task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d,
                       input logic [31:0] e);
        select = 1'b1; write_en = we; addr = a; data_i = d;
        exp_q.push_back('{chk: ~we, val: e, a: a});
        @(posedge clk); #1;
        select = 1'b0; write_en = 1'b0; data_i = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        do_reset();
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", ready); end
        n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL rst_data_o: got %h want 0", data_o); end
        n_vec++; if (leds !== '0) begin n_err++; $display("FAIL rst_leds: got %b want 0", leds); end
        for (int a = 0; a < 8; a++) begin
            e = (a == 3) ? 32'(BDR) : (a == 6) ? status_now() : 32'h0;
            select = 1'b1; write_en = 1'b0; addr = 3'(a);
            exp_q.push_back('{chk: 1'b1, val: e, a: 3'(a)});
            n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL pre_ready[%0d]: got %b want 0", a, ready); end
            @(posedge clk); #1;
            select = 1'b0;
            n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL ready_rise[%0d]: got %b want 1", a, ready); end
            @(posedge clk); #1;
            n_vec++;
            if (ready !== 1'b0 || data_o !== 32'h0) begin
                n_err++;
                $display("FAIL ready_fall[%0d]: got ready=%b data_o=%h want 0/0", a, ready, data_o);
            end
        end
    endtask

    task automatic test_out();
        do_reset();
        bus(1'b1, REG_OUT, 32'h2A, 32'h0);
        n_vec++; if (leds !== 6'b101010) begin n_err++; $display("FAIL out_leds: got %b want 101010", leds); end
        bus(1'b0, REG_OUT, 32'h0, 32'h2A);
        bus(1'b1, REG_OUT, 32'hFFFF_FFFF, 32'h0);
        bus(1'b0, REG_OUT, 32'h0, 32'h3F);
        n_vec++; if (leds !== 6'h3F) begin n_err++; $display("FAIL out_leds_all: got %b want 111111", leds); end
        bus(1'b1, REG_DUTY, 32'hFFFF_FFFF, 32'h0);
        bus(1'b0, REG_DUTY, 32'h0, 32'hFF);
        bus(1'b1, REG_BLINK_DIV, 32'hFFFF_FFFF, 32'h0);
        bus(1'b0, REG_BLINK_DIV, 32'h0, 32'h00FF_FFFF);
        bus(1'b1, REG_PWM_EN, 32'hFFFF_FFC1, 32'h0);
        bus(1'b0, REG_PWM_EN, 32'h0, 32'h01);
    endtask

    task automatic test_toggle();
        do_reset();
        bus(1'b1, REG_OUT, 32'h3F, 32'h0);
        bus(1'b1, REG_TOGGLE, 32'h05, 32'h0);
        bus(1'b0, REG_OUT, 32'h0, 32'h3A);
        bus(1'b0, REG_TOGGLE, 32'h0, 32'h0);
        n_vec++; if (leds !== 6'h3A) begin n_err++; $display("FAIL toggle_leds: got %b want 111010", leds); end
        bus(1'b1, REG_STATUS, 32'hFFFF_FFFF, 32'h0);
        bus(1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0);
        bus(1'b0, 3'd7, 32'h0, 32'h0);
        bus(1'b0, REG_OUT, 32'h0, 32'h3A);
    endtask

    // Starts one cycle after a BLINK_DIV=3 write commit with phase=0.
    task automatic blink_window(input int n);
        logic e;
        for (int m = 1; m <= n; m++) begin
            if (m > 1) begin @(posedge clk); #1; end
            e = 1'(((m - 1) / 4) % 2);
            n_vec++;
            if (leds !== {5'b0, e}) begin
                n_err++;
                $display("FAIL blink[m=%0d]: got %b want %b", m, leds, {5'b0, e});
            end
        end
    endtask

    task automatic test_blink();
        do_reset();
        bus(1'b1, REG_OUT, 32'h01, 32'h0);
        bus(1'b1, REG_BLINK_EN, 32'h01, 32'h0);
        bus(1'b1, REG_BLINK_DIV, 32'h3, 32'h0);
        blink_window(33);
        bus(1'b1, REG_BLINK_DIV, 32'h3, 32'h0);
        blink_window(17);
    endtask

    task automatic test_pwm();
        int duties[4] = '{64, 0, 255, 128};
        int cnt;
        logic stray;
        do_reset();
        bus(1'b1, REG_OUT, 32'h02, 32'h0);
        bus(1'b1, REG_PWM_EN, 32'h02, 32'h0);
        foreach (duties[k]) begin
            bus(1'b1, REG_DUTY, 32'(duties[k]), 32'h0);
            cnt = 0;
            stray = 1'b0;
            for (int i = 0; i < 256; i++) begin
                if (leds[1] === 1'b1) cnt++;
                if ((leds & 6'b111101) !== 6'b0) stray = 1'b1;
                @(posedge clk); #1;
            end
            n_vec++;
            if (cnt != duties[k] || stray) begin
                n_err++;
                $display("FAIL pwm_duty%0d: got %0d high (stray=%b) want %0d", duties[k], cnt, stray, duties[k]);
            end
        end
        bus(1'b0, REG_STATUS, 32'h0, status_now());
    endtask

    task automatic test_back_to_back();
        int pulses;
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back('{chk: 1'b0, val: 32'h0, a: REG_TOGGLE});
        select = 1'b1; write_en = 1'b1; addr = REG_TOGGLE; data_i = 32'h1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) pulses++;
        end
        select = 1'b0; write_en = 1'b0; data_i = '0;
        n_vec++; if (pulses != 3) begin n_err++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
        n_vec++; if (leds !== 6'h01) begin n_err++; $display("FAIL b2b_leds: got %b want 000001", leds); end
        @(posedge clk); #1;
        bus(1'b0, REG_OUT, 32'h0, 32'h01);
    endtask

    task automatic test_reset_on_accept();
        do_reset();
        bus(1'b1, REG_OUT, 32'h3F, 32'h0);
        n_vec++; if (leds !== 6'h3F) begin n_err++; $display("FAIL roa_pre_leds: got %b want 111111", leds); end
        select = 1'b1; write_en = 1'b1; addr = REG_OUT; data_i = 32'h15; reset = 1'b1;
        @(posedge clk); #1;
        rst_cyc = cyc;
        select = 1'b0; write_en = 1'b0; data_i = '0; reset = 1'b0;
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL roa_ready: got %b want 0", ready); end
        n_vec++; if (leds !== '0) begin n_err++; $display("FAIL roa_leds: got %b want 0", leds); end
        @(posedge clk); #1;
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL roa_ready_late: got %b want 0", ready); end
        bus(1'b0, REG_OUT, 32'h0, 32'h0);
        bus(1'b0, REG_BLINK_DIV, 32'h0, 32'(BDR));
    endtask

    initial begin
        reset = 1'b1; select = 1'b0; write_en = 1'b0; addr = '0; data_i = '0;
        test_reset();
        test_out();
        test_toggle();
        test_blink();
        test_pwm();
        test_back_to_back();
        test_reset_on_accept();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_ready_end: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
